gray_bcd_converter: RTL and testbench

- Upstream neighbour of the two-digit seven-segment driver.
- Synchronises an asynchronous Gray-coded input (switches or encoder) and converts it to binary.
- Runs a sequential shift-and-add-3 (double dabble) conversion to two packed BCD digits.
- Presents a stable bcd_o[7:0] (tens in [7:4], units in [3:0]) that feeds the display driver's bcd_i.

---
 rtl/gray_bcd_converter.sv | 108 ++++++++++
 tb/tb_gray_bcd_converter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_bcd_converter.sv
// Gray-to-binary-to-BCD converter: synchronises an asynchronous Gray code and
// runs a sequential double-dabble conversion into two packed BCD digits.
module gray_bcd_converter #(
  parameter int GRAY_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [GRAY_WIDTH-1:0] gray_i,
  output logic [7:0]            bcd_o,
  output logic [GRAY_WIDTH-1:0] binary_o,
  output logic                  valid_o,
  output logic                  busy_o
);

  localparam int W  = GRAY_WIDTH;
  localparam int SW = 8 + W;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state, next_state;
  logic [W-1:0]   sync1, sync2, last_gray;
  logic [W-1:0]   bin_comb, bin_q;
  logic           force_q;
  logic [SW-1:0]  shreg, shreg_adj;
  logic [2:0]     count;

  // Binary bit i is the XOR of all Gray bits at or above position i.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      bin_comb[i] = ^(sync2 >> i);
    end
  end

  // Add-3 correction on each BCD nibble before the shift.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shreg_adj = shreg;
    if (shreg[W+3:W] >= 4'd5)   shreg_adj[W+3:W]   = shreg[W+3:W]   + 4'd3;
    if (shreg[W+7:W+4] >= 4'd5) shreg_adj[W+7:W+4] = shreg[W+7:W+4] + 4'd3;
  end

  // NOTE: sequential state always uses non-blocking assignments to avoid races.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if ((sync2 != last_gray) || force_q) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (count == 3'd1) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1     <= '0;
      sync2     <= '0;
      last_gray <= '0;
      force_q   <= 1'b1;
      bcd_o     <= 8'h00;
      binary_o  <= '0;
      valid_o   <= 1'b0;
    end else begin
      sync1   <= gray_i;
      sync2   <= sync1;
      valid_o <= 1'b0;
      case (state)
        LOAD: begin
          last_gray <= sync2;
          force_q   <= 1'b0;
        end
        DONE: begin
          bcd_o    <= shreg[SW-1:W];
          binary_o <= bin_q;
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the conversion datapath is left unreset; LOAD always initialises it
  // before SHIFT or DONE reads it.
  always_ff @(posedge clk_i) begin
    case (state)
      LOAD: begin
        shreg <= {8'h00, bin_comb};
        bin_q <= bin_comb;
        count <= 3'(W);
      end
      SHIFT: begin
        shreg <= {shreg_adj[SW-2:0], 1'b0};
        count <= count - 3'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gray_bcd_converter.sv
// Directed bench for gray_bcd_converter: a 4-bit and a 6-bit instance share
// clock and reset; each task drives one scenario and checks inline.
module tb_gray_bcd_converter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] gray4;
  logic [5:0] gray6;
  logic [7:0] bcd4, bcd6;
  logic [3:0] bin4;
  logic [5:0] bin6;
  logic       valid4, valid6, busy4, busy6;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gray_bcd_converter #(.GRAY_WIDTH(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .gray_i(gray4),
    .bcd_o(bcd4), .binary_o(bin4), .valid_o(valid4), .busy_o(busy4)
  );

  gray_bcd_converter #(.GRAY_WIDTH(6)) dut6 (
    .clk_i(clk_i), .rst_i(rst_i), .gray_i(gray6),
    .bcd_o(bcd6), .binary_o(bin6), .valid_o(valid6), .busy_o(busy6)
  );

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    int p4, p6;
    rst_i = 1'b1; gray4 = 4'b0000; gray6 = 6'b000000;
    repeat (3) tick();
    checks++; if (bcd4 !== 8'h00)  begin errors++; $display("FAIL reset_bcd4 got %h want 00", bcd4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", valid4); end
    checks++; if (busy4 !== 1'b0)  begin errors++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    checks++; if (bcd6 !== 8'h00)  begin errors++; $display("FAIL reset_bcd6 got %h want 00", bcd6); end
    checks++; if (busy6 !== 1'b0)  begin errors++; $display("FAIL reset_busy6 got %b want 0", busy6); end
    rst_i = 1'b0;
    p4 = 0; p6 = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (valid4 === 1'b1) p4++;
      if (valid6 === 1'b1) p6++;
    end
    checks++; if (p4 != 1) begin errors++; $display("FAIL release_pulses4 got %0d want 1", p4); end
    checks++; if (p6 != 1) begin errors++; $display("FAIL release_pulses6 got %0d want 1", p6); end
    checks++; if (bcd4 !== 8'h00) begin errors++; $display("FAIL release_bcd4 got %h want 00", bcd4); end
    checks++; if (bin4 !== 4'h0)  begin errors++; $display("FAIL release_bin4 got %h want 0", bin4); end
  endtask

  task automatic test_single();
    gray4 = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) begin
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL single_busy_early got %b want 0", busy4); end
      end
      if (k == 3) begin
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL single_busy_load got %b want 1", busy4); end
      end
      if (k == 8) begin
        checks++; if (bcd4 !== 8'h00)  begin errors++; $display("FAIL single_bcd_early got %h want 00", bcd4); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", valid4); end
        checks++; if (busy4 !== 1'b1)  begin errors++; $display("FAIL single_busy_done got %b want 1", busy4); end
      end
      if (k == 9) begin
        checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", valid4); end
        checks++; if (bcd4 !== 8'h15)  begin errors++; $display("FAIL single_bcd got %h want 15", bcd4); end
        checks++; if (bin4 !== 4'hF)   begin errors++; $display("FAIL single_bin got %h want f", bin4); end
      end
      if (k == 10) begin
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL single_valid_width got %b want 0", valid4); end
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [7:0] bcd_tbl [16]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                  8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11,
                                  8'h12, 8'h13, 8'h14, 8'h15};
    int p;
    for (int i = 0; i < 16; i++) begin
      gray4 = gray_tbl[i];
      p = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (valid4 === 1'b1) p++;
      end
      checks++; if (p != 1) begin errors++; $display("FAIL sweep_pulses code %b got %0d want 1", gray_tbl[i], p); end
      checks++; if (bcd4 !== bcd_tbl[i]) begin errors++; $display("FAIL sweep_bcd code %b got %h want %h", gray_tbl[i], bcd4, bcd_tbl[i]); end
      checks++; if (bin4 !== 4'(i)) begin errors++; $display("FAIL sweep_bin code %b got %0d want %0d", gray_tbl[i], bin4, i); end
    end
  endtask

  task automatic test_mid_change();
    int p;
    logic [7:0] first_bcd, last_bcd;
    p = 0; first_bcd = 8'hxx; last_bcd = 8'hxx;
    gray4 = 4'b0111;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 4) gray4 = 4'b1111;
      if (valid4 === 1'b1) begin
        p++;
        if (p == 1) first_bcd = bcd4;
        last_bcd = bcd4;
      end
    end
    checks++; if (p != 2) begin errors++; $display("FAIL mid_pulses got %0d want 2", p); end
    checks++; if (first_bcd !== 8'h05) begin errors++; $display("FAIL mid_first_bcd got %h want 05", first_bcd); end
    checks++; if (last_bcd !== 8'h10)  begin errors++; $display("FAIL mid_second_bcd got %h want 10", last_bcd); end
    checks++; if (bcd4 !== 8'h10) begin errors++; $display("FAIL mid_final_bcd got %h want 10", bcd4); end
    checks++; if (bin4 !== 4'hA)  begin errors++; $display("FAIL mid_final_bin got %h want a", bin4); end
  endtask

  task automatic test_reset_mid_shift();
    int p;
    logic [7:0] first_bcd;
    gray4 = 4'b0010;
    repeat (5) tick();
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", busy4); end
    rst_i = 1'b1;
    tick();
    checks++; if (bcd4 !== 8'h00)  begin errors++; $display("FAIL rmid_bcd got %h want 00", bcd4); end
    checks++; if (bin4 !== 4'h0)   begin errors++; $display("FAIL rmid_bin got %h want 0", bin4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid4); end
    checks++; if (busy4 !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b want 0", busy4); end
    rst_i = 1'b0;
    p = 0; first_bcd = 8'hxx;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (valid4 === 1'b1) begin
        p++;
        if (p == 1) first_bcd = bcd4;
      end
    end
    checks++; if (p != 2) begin errors++; $display("FAIL rmid_pulses got %0d want 2", p); end
    checks++; if (first_bcd !== 8'h00) begin errors++; $display("FAIL rmid_forced_bcd got %h want 00", first_bcd); end
    checks++; if (bcd4 !== 8'h03) begin errors++; $display("FAIL rmid_final_bcd got %h want 03", bcd4); end
    checks++; if (bin4 !== 4'h3)  begin errors++; $display("FAIL rmid_final_bin got %h want 3", bin4); end
  endtask

  task automatic test_w6();
    int p;
    gray6 = 6'b100000;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin
        checks++; if (valid6 !== 1'b0) begin errors++; $display("FAIL w6_valid_early got %b want 0", valid6); end
        checks++; if (bcd6 !== 8'h00)  begin errors++; $display("FAIL w6_bcd_early got %h want 00", bcd6); end
      end
      if (k == 11) begin
        checks++; if (valid6 !== 1'b1) begin errors++; $display("FAIL w6_valid got %b want 1", valid6); end
        checks++; if (bcd6 !== 8'h63)  begin errors++; $display("FAIL w6_bcd got %h want 63", bcd6); end
        checks++; if (bin6 !== 6'd63)  begin errors++; $display("FAIL w6_bin got %0d want 63", bin6); end
      end
    end
    p = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (valid6 === 1'b1) p++;
    end
    checks++; if (p != 0) begin errors++; $display("FAIL w6_hold_pulses got %0d want 0", p); end
    checks++; if (bcd6 !== 8'h63) begin errors++; $display("FAIL w6_hold_bcd got %h want 63", bcd6); end
  endtask

  initial begin
    rst_i = 1'b1;
    gray4 = '0;
    gray6 = '0;
    test_reset();
    test_single();
    test_sweep();
    test_mid_change();
    test_reset_mid_shift();
    test_w6();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
